// File: rtl/rv32i_types.sv
// Shared RV32I decode types, control word and queue entry for decode_queue.
// Optional RV32M fields are present only when DECODE_QUEUE_MULDIV_EN is defined.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000, sh = 3'b001, sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
    axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic {am1_rs1_out = 1'b0, am1_pc_out = 1'b1} alumux1_sel_t;

  typedef enum logic [2:0] {
    am2_i_imm = 3'd0, am2_u_imm = 3'd1, am2_b_imm = 3'd2,
    am2_s_imm = 3'd3, am2_j_imm = 3'd4, am2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic {cm_rs2_out = 1'b0, cm_i_imm = 1'b1} cmpmux_sel_t;

  typedef enum logic [3:0] {
    rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw = 4'd3, rf_pc_plus4 = 4'd4,
    rf_lb = 4'd5, rf_lbu = 4'd6, rf_lh = 4'd7, rf_lhu = 4'd8
  } regfilemux_sel_t;

  typedef enum logic {mm_pc_out = 1'b0, mm_alu_out = 1'b1} marmux_sel_t;

`ifdef DECODE_QUEUE_MULDIV_EN
  typedef enum logic [2:0] {
    mul = 3'b000, mulh = 3'b001, mulhsu = 3'b010, mulhu = 3'b011,
    div = 3'b100, divu = 3'b101, rem = 3'b110, remu = 3'b111
  } muldiv_funct3_t;
`endif

  typedef struct packed {
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            br;
    logic            jump;
`ifdef DECODE_QUEUE_MULDIV_EN
    logic            muldiv;
    muldiv_funct3_t  muldiv_op;
`endif
  } rv32i_control_word;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Widest PC a queue entry can carry; narrower PC_W values are zero-extended.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    rv32i_control_word     ctrl;
    logic [31:0]           instr;
    logic [PC_MAX_W-1:0]   pc;
    logic                  illegal;
  } decode_entry_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: raw instruction to control word plus illegal flag.
// RV32M decode on op_reg/funct7=0000001 is enabled by DECODE_QUEUE_MULDIV_EN.
module instr_decoder
  import rv32i_types::*;
(
  input  logic [31:0]       instr,
  output rv32i_control_word ctrl,
  output logic              illegal
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  rv32i_control_word dec;
  logic              bad;
  logic              unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // NOTE: dec and bad get defaults before the case so every path assigns them; no latch.
  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.opcode = rv32i_opcode'(opcode);
    dec.funct3 = funct3;
    dec.funct7 = funct7;
    case (opcode)
      op_lui: begin
        dec.load_regfile   = 1'b1;
        dec.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        dec.alumux1_sel  = am1_pc_out;
        dec.alumux2_sel  = am2_u_imm;
        dec.load_regfile = 1'b1;
      end
      op_jal: begin
        dec.alumux1_sel    = am1_pc_out;
        dec.alumux2_sel    = am2_j_imm;
        dec.load_regfile   = 1'b1;
        dec.regfilemux_sel = rf_pc_plus4;
        dec.jump           = 1'b1;
      end
      op_jalr: begin
        dec.alumux2_sel    = am2_i_imm;
        dec.load_regfile   = 1'b1;
        dec.regfilemux_sel = rf_pc_plus4;
        dec.jump           = 1'b1;
      end
      op_br: begin
        dec.alumux1_sel = am1_pc_out;
        dec.alumux2_sel = am2_b_imm;
        dec.cmpop       = branch_funct3_t'(funct3);
        dec.br          = 1'b1;
        bad             = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      op_load: begin
        dec.alumux2_sel  = am2_i_imm;
        dec.marmux_sel   = mm_alu_out;
        dec.mem_read     = 1'b1;
        dec.load_regfile = 1'b1;
        case (funct3)
          lb:      dec.regfilemux_sel = rf_lb;
          lh:      dec.regfilemux_sel = rf_lh;
          lw:      dec.regfilemux_sel = rf_lw;
          lbu:     dec.regfilemux_sel = rf_lbu;
          lhu:     dec.regfilemux_sel = rf_lhu;
          default: bad = 1'b1;
        endcase
      end
      op_store: begin
        dec.alumux2_sel = am2_s_imm;
        dec.marmux_sel  = mm_alu_out;
        dec.mem_write   = 1'b1;
        bad             = (funct3 > 3'b010);
      end
      op_imm: begin
        dec.alumux2_sel  = am2_i_imm;
        dec.load_regfile = 1'b1;
        case (funct3)
          slt:  begin dec.cmpop = blt;  dec.cmpmux_sel = cm_i_imm; dec.regfilemux_sel = rf_br_en; end
          sltu: begin dec.cmpop = bltu; dec.cmpmux_sel = cm_i_imm; dec.regfilemux_sel = rf_br_en; end
          sll: begin
            dec.aluop = alu_sll;
            bad       = (funct7 != F7_BASE);
          end
          sr: begin
            dec.aluop = funct7[5] ? alu_sra : alu_srl;
            bad       = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          default: dec.aluop = alu_ops'(funct3);
        endcase
      end
      op_reg: begin
        dec.alumux2_sel  = am2_rs2_out;
        dec.load_regfile = 1'b1;
        if ((funct7 == F7_BASE) ||
            ((funct7 == F7_ALT) && ((funct3 == add) || (funct3 == sr)))) begin
          case (funct3)
            add:     dec.aluop = funct7[5] ? alu_sub : alu_add;
            sr:      dec.aluop = funct7[5] ? alu_sra : alu_srl;
            slt:     begin dec.cmpop = blt;  dec.regfilemux_sel = rf_br_en; end
            sltu:    begin dec.cmpop = bltu; dec.regfilemux_sel = rf_br_en; end
            default: dec.aluop = alu_ops'(funct3);
          endcase
        end
`ifdef DECODE_QUEUE_MULDIV_EN
        else if (funct7 == F7_MULDIV) begin
          dec.muldiv    = 1'b1;
          dec.muldiv_op = muldiv_funct3_t'(funct3);
        end
`endif
        else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
  end

  assign illegal = bad;
  assign ctrl    = bad ? '0 : dec;

endmodule

// File: rtl/decode_queue.sv
// Decode-and-buffer stage between fetch and issue: DEPTH-entry FIFO of decoded
// instructions with valid/ready on both sides and synchronous flush. Macro: DECODE_QUEUE_MULDIV_EN.
module decode_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output rv32i_control_word        out_ctrl,
  output logic [31:0]              out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  decode_entry_t     mem [DEPTH];
  decode_entry_t     wr_entry;
  decode_entry_t     head;
  rv32i_control_word dec_ctrl;
  logic              dec_illegal;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              unused_head_pc;

  instr_decoder u_decoder (
    .instr   (in_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Both handshakes look only at the registered count, so a pop never opens in_ready early.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_entry         = '0;
    wr_entry.ctrl    = dec_ctrl;
    wr_entry.instr   = in_instr;
    wr_entry.pc      = PC_MAX_W'(in_pc);
    wr_entry.illegal = dec_illegal;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; out_valid gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head           = mem[rd_ptr];
  assign unused_head_pc = ^head.pc;

  assign out_ctrl    = out_valid ? head.ctrl : '0;
  assign out_instr   = out_valid ? head.instr : '0;
  assign out_pc      = out_valid ? head.pc[PC_W-1:0] : '0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;
  assign occupancy   = count;

endmodule

// File: tb/tb_decode_queue.sv
// Randomised scoreboard bench for decode_queue with directed handshake, flush and reset cases.
// Expectations follow DECODE_QUEUE_MULDIV_EN when it is defined for the build.
module tb_decode_queue;
  import rv32i_types::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
`ifdef DECODE_QUEUE_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  typedef struct packed {
    rv32i_control_word ctrl;
    logic [31:0]       instr;
    logic [PC_W-1:0]   pc;
    logic              illegal;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [PC_W-1:0]        in_pc;
  logic                   out_valid;
  logic                   out_ready;
  rv32i_control_word      out_ctrl;
  logic [31:0]            out_instr;
  logic [PC_W-1:0]        out_pc;
  logic                   out_illegal;
  logic [$clog2(DEPTH):0] occupancy;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  logic [6:0] op_tab [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1111111,
                              7'b1110011};

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Legality straight from the instruction-set rules.
  function automatic bit legal(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: ok = 1;
      7'b1100011: ok = !(f3 inside {3'b010, 3'b011});
      7'b0000011: ok = !(f3 inside {3'b011, 3'b110, 3'b111});
      7'b0100011: ok = (f3 <= 3'b010);
      7'b0010011: ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                       (f3 == 3'b101) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
      7'b0110011: ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'b000, 3'b101})) ||
                       (MULDIV_EN && (f7 == 7'h01));
      default:    ok = 0;
    endcase
    return ok && (i[1:0] == 2'b11);
  endfunction

  function automatic exp_t ref_model(input logic [31:0] i, input logic [PC_W-1:0] pc);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    e = '0;
    e.instr   = i;
    e.pc      = pc;
    e.illegal = !legal(i);
    if (!e.illegal) begin
      e.ctrl.opcode = rv32i_opcode'(op);
      e.ctrl.funct3 = f3;
      e.ctrl.funct7 = f7;
      case (op)
        7'b0110111: begin e.ctrl.load_regfile = 1; e.ctrl.regfilemux_sel = rf_u_imm; end
        7'b0010111: begin
          e.ctrl.alumux1_sel = am1_pc_out; e.ctrl.alumux2_sel = am2_u_imm;
          e.ctrl.load_regfile = 1; e.ctrl.regfilemux_sel = rf_alu_out;
        end
        7'b1101111: begin
          e.ctrl.alumux1_sel = am1_pc_out; e.ctrl.alumux2_sel = am2_j_imm;
          e.ctrl.load_regfile = 1; e.ctrl.regfilemux_sel = rf_pc_plus4; e.ctrl.jump = 1;
        end
        7'b1100111: begin
          e.ctrl.alumux2_sel = am2_i_imm; e.ctrl.load_regfile = 1;
          e.ctrl.regfilemux_sel = rf_pc_plus4; e.ctrl.jump = 1;
        end
        7'b1100011: begin
          e.ctrl.alumux1_sel = am1_pc_out; e.ctrl.alumux2_sel = am2_b_imm;
          e.ctrl.cmpop = branch_funct3_t'(f3); e.ctrl.cmpmux_sel = cm_rs2_out; e.ctrl.br = 1;
        end
        7'b0000011: begin
          e.ctrl.alumux2_sel = am2_i_imm; e.ctrl.marmux_sel = mm_alu_out;
          e.ctrl.mem_read = 1; e.ctrl.load_regfile = 1;
          case (f3)
            3'b000:  e.ctrl.regfilemux_sel = rf_lb;
            3'b001:  e.ctrl.regfilemux_sel = rf_lh;
            3'b010:  e.ctrl.regfilemux_sel = rf_lw;
            3'b100:  e.ctrl.regfilemux_sel = rf_lbu;
            default: e.ctrl.regfilemux_sel = rf_lhu;
          endcase
        end
        7'b0100011: begin
          e.ctrl.alumux2_sel = am2_s_imm; e.ctrl.marmux_sel = mm_alu_out; e.ctrl.mem_write = 1;
        end
        default: begin
          // op_imm and op_reg share the arithmetic table; they differ in operand and sub/muldiv.
          e.ctrl.load_regfile = 1;
          e.ctrl.alumux2_sel  = (op == 7'b0110011) ? am2_rs2_out : am2_i_imm;
          if (op == 7'b0110011 && f7 == 7'h01) begin
`ifdef DECODE_QUEUE_MULDIV_EN
            e.ctrl.muldiv    = 1;
            e.ctrl.muldiv_op = muldiv_funct3_t'(f3);
`endif
          end else begin
            case (f3)
              3'b000: e.ctrl.aluop = (op == 7'b0110011 && f7 == 7'h20) ? alu_sub : alu_add;
              3'b001: e.ctrl.aluop = alu_sll;
              3'b010, 3'b011: begin
                e.ctrl.cmpop          = (f3 == 3'b010) ? blt : bltu;
                e.ctrl.cmpmux_sel     = (op == 7'b0110011) ? cm_rs2_out : cm_i_imm;
                e.ctrl.regfilemux_sel = rf_br_en;
              end
              3'b100: e.ctrl.aluop = alu_xor;
              3'b101: e.ctrl.aluop = (f7 == 7'h20) ? alu_sra : alu_srl;
              3'b110: e.ctrl.aluop = alu_or;
              default: e.ctrl.aluop = alu_and;
            endcase
          end
        end
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r      = $urandom;
    r[6:0] = op_tab[$urandom_range(0, 10)];
    if (r[6:0] inside {7'b0110011, 7'b0010011}) begin
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ($urandom_range(0, 19) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Monitor: compares DUT state and popped heads against the scoreboard queue.
  initial begin : monitor
    exp_t e;
    int   sz;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
      end else begin
        sz = sb_q.size();
        check("occupancy", 128'(occupancy), 128'(sz));
        check("out_valid", 128'(out_valid), 128'(sz != 0));
        check("in_ready", 128'(in_ready), 128'(sz != DEPTH));
        if (sz == 0)
          check("gated_outputs", {out_ctrl, out_instr, out_pc, out_illegal}, '0);
        if (flush) begin
          sb_q.delete();
        end else begin
          if (out_ready && sz != 0) begin
            e = sb_q.pop_front();
            check("head_ctrl", 128'(out_ctrl), 128'(e.ctrl));
            check("head_instr", 128'(out_instr), 128'(e.instr));
            check("head_pc", 128'(out_pc), 128'(e.pc));
            check("head_illegal", 128'(out_illegal), 128'(e.illegal));
          end
          if (in_valid && sz != DEPTH) sb_q.push_back(ref_model(in_instr, in_pc));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                      input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 0; flush = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_occupancy", 128'(occupancy), 128'(0));

    // addi x1,x0,5 appears one edge after the push, not combinationally.
    in_valid = 1; in_instr = 32'h0050_0093; in_pc = 32'h100; out_ready = 0; #1;
    check("no_bypass", 128'(out_valid), 128'(0));
    step(1, 32'h0050_0093, 32'h100, 0, 0);
    check("addi_valid", 128'(out_valid), 128'(1));
    check("addi_load_regfile", 128'(out_ctrl.load_regfile), 128'(1));
    check("addi_aluop", 128'(out_ctrl.aluop), 128'(alu_add));
    check("addi_pc", 128'(out_pc), 128'(32'h100));
    check("addi_occupancy", 128'(occupancy), 128'(1));
    step(0, '0, '0, 1, 0);

    // Fill to DEPTH, then a pop must not open in_ready in the same cycle.
    for (int k = 0; k < DEPTH; k++) step(1, rand_instr(), PC_W'(32'h200 + 4 * k), 0, 0);
    check("full_in_ready", 128'(in_ready), 128'(0));
    check("full_occupancy", 128'(occupancy), 128'(DEPTH));
    step(1, 32'h0010_0113, 32'h2F0, 0, 0);
    check("full_reject", 128'(occupancy), 128'(DEPTH));
    in_valid = 1; in_instr = 32'h0020_0193; in_pc = 32'h2F4; out_ready = 1; #1;
    check("full_pop_same_cycle", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    check("after_pop_occupancy", 128'(occupancy), 128'(DEPTH - 1));
    check("after_pop_in_ready", 128'(in_ready), 128'(1));
    repeat (DEPTH - 1) step(0, '0, '0, 1, 0);

    // Streaming across pointer wrap.
    step(1, rand_instr(), 32'h300, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1, rand_instr(), PC_W'(32'h300 + 4 * k), 1, 0);
      check("stream_occupancy", 128'(occupancy), 128'(1));
    end
    step(0, '0, '0, 1, 0);

    // Flush with a same-cycle push and pop.
    for (int k = 0; k < 3; k++) step(1, rand_instr(), PC_W'(32'h400 + 4 * k), 0, 0);
    step(1, 32'h0030_0213, 32'h4F0, 1, 1);
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_occupancy", 128'(occupancy), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    repeat (2) step(0, '0, '0, 1, 0);

    // Unknown opcode followed by mul.
    step(1, 32'h0000_007F, 32'h500, 0, 0);
    step(1, 32'h0220_8033, 32'h504, 0, 0);
    check("unknown_illegal", 128'(out_illegal), 128'(1));
    check("unknown_ctrl", 128'(out_ctrl), 128'(0));
    step(0, '0, '0, 1, 0);
`ifdef DECODE_QUEUE_MULDIV_EN
    check("mul_muldiv", 128'(out_ctrl.muldiv), 128'(1));
    check("mul_illegal", 128'(out_illegal), 128'(0));
`else
    check("mul_illegal", 128'(out_illegal), 128'(1));
    check("mul_ctrl", 128'(out_ctrl), 128'(0));
`endif
    step(0, '0, '0, 1, 0);

    // Asynchronous reset between edges with two entries queued.
    step(1, rand_instr(), 32'h600, 0, 0);
    step(1, rand_instr(), 32'h604, 0, 0);
    check("pre_reset_occupancy", 128'(occupancy), 128'(2));
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 128'(out_valid), 128'(0));
    check("async_reset_occupancy", 128'(occupancy), 128'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 128'(in_ready), 128'(1));

    // Random traffic: a draining phase and a back-pressured phase.
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 99) < 70, rand_instr(), PC_W'($urandom), $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 3);
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 99) < 80, rand_instr(), PC_W'($urandom), $urandom_range(0, 99) < 25,
           $urandom_range(0, 199) < 3);
    repeat (DEPTH + 2) step(0, '0, '0, 1, 0);
    check("drained", 128'(occupancy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the combinational control-word decoder.
- Accepts raw fetched instructions with a valid/ready handshake, decodes each to rv32i_control_word plus an illegal-instruction flag, and buffers the results in a DEPTH-entry FIFO.
- Sits between fetch and issue. Decouples fetch stalls from execute stalls and supports a synchronous flush on redirect.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- PC_W, 32, width of the PC carried with each entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all entries and any same-cycle input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head this cycle.
- out_ctrl  out  rv32i_control_word  decoded control of head.
- out_instr  out  32  raw instruction of head (used for immediates and register indices).
- out_pc  out  PC_W  PC of head.
- out_illegal  out  1  head decoded as illegal.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - read/write pointers = 0, count = 0.
  - out_valid=0, occupancy=0, in_ready=1 after release.
  - Storage contents are don't-care.
- Push: in_valid && in_ready && !flush. The combinationally decoded entry is written at wr_ptr and wr_ptr increments.
- Pop: out_valid && out_ready && !flush. rd_ptr increments.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no combinational in→out bypass, even when the queue is empty.
- Ready/valid:
  - in_ready = (count != DEPTH). Registered-count based; does not depend on out_ready.
  - When full, a simultaneous pop does not open in_ready in that cycle.
  - out_valid = (count != 0).
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count saturates by construction and never exceeds DEPTH or underflows.
- Output gating: when out_valid=0, out_ctrl, out_instr, out_pc and out_illegal are driven to '0.
- Flush has priority over push and pop. At the next edge count=0 and pointers=0. The same-cycle input is dropped and in_ready stays 1.
- Asynchronous reset mid-operation clears everything immediately, regardless of handshakes in flight.
- Decode rules:
  - Identical to the existing control-word mapping for lui, auipc, jal, jalr, br, load, store, op_imm and op_reg.
  - The opcode, funct3 and funct7 fields are copied into ctrl.
- out_illegal=1 and ctrl forced to '0 for any of:
  - unknown opcode;
  - op_reg with funct7 not 0000000, or 0100000 only with funct3 add/sr;
  - op_imm sll with funct7≠0;
  - op_imm sr with funct7 ∉ {0000000, 0100000};
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010;
  - br funct3 ∈ {010, 011};
  - instr[1:0] ≠ 11.
- Illegal entries are queued and handshaked like legal ones. Trap handling is done downstream.

Optional Feature:
- Macro: DECODE_QUEUE_MULDIV_EN.
- Defined:
  - op_reg with funct7=0000001 decodes as RV32M.
  - ctrl.muldiv=1, ctrl.muldiv_op=funct3, load_regfile=1, regfilemux_sel=alu_out, out_illegal=0.
  - The muldiv fields exist in the control word.
- Undefined:
  - funct7=0000001 is illegal (ctrl='0, out_illegal=1).
  - The muldiv fields are absent from the struct.

Decomposition:
- rv32i_types package additions:
  - decode_entry_t struct {ctrl, instr, pc, illegal};
  - muldiv_funct3_t enum and muldiv fields in rv32i_control_word, both under DECODE_QUEUE_MULDIV_EN;
  - constants F7_BASE=7'b0000000, F7_ALT=7'b0100000, F7_MULDIV=7'b0000001.
- Sub-module instr_decoder: purely combinational, maps instr to {ctrl, illegal}.
- decode_queue holds the FIFO storage, pointers, count, flush and handshake logic.

Test Plan:
- Reset, then push addi x1,x0,5 (0x00500093) at pc 0x100 with out_ready=0:
  - one cycle later out_valid=1, out_ctrl.load_regfile=1, aluop=alu_add, out_pc=0x100, occupancy=1.
- Push 4 instructions with out_ready=0:
  - in_ready=0 after the 4th push and occupancy=4.
  - A 5th in_valid is not accepted.
  - Asserting out_ready with in_valid=1 pops one; in_ready returns to 1 only the following cycle.
- Continuous push and pop for 10 instructions at DEPTH=4:
  - output order matches input order across pointer wrap.
  - occupancy stays 1 and no entry is lost or duplicated.
- Fill 3 entries, then assert flush together with in_valid and out_ready:
  - next cycle out_valid=0, occupancy=0, and the flushed input never appears.
- Push 0x0000007F (unknown opcode) and 0x02208033 (mul):
  - first entry: out_illegal=1, ctrl='0.
  - second entry: illegal without the macro; muldiv=1 with the macro.
- Deassert rst_n asynchronously mid-stream with 2 entries queued:
  - out_valid and occupancy drop to 0 immediately, without waiting for a clock edge.
